// File: rtl/board_scanner.sv
// Turns VGA raster timing into a per-pixel cell_alive stream by fetching packed board words.
// Latency: READ_LATENCY+2 cycles (4 by default) from any pixel input to its outputs.
// No backpressure: the raster advances every clock and the board memory has fixed read latency.
module board_scanner #(
  parameter int BOARD_SIZE   = 256,
  parameter int WORD_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  blank_in,
  output logic                  rd_en_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  input  logic [WORD_WIDTH-1:0] rd_data_in,
  output logic                  cell_alive_out,
  output logic [10:0]           hcount_out,
  output logic [9:0]            vcount_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  blank_out,
  output logic                  scan_active_out,
  output logic                  frame_done_out
);

  localparam int LATENCY = READ_LATENCY + 2;
  localparam int WSH     = $clog2(WORD_WIDTH);
  localparam int WPR     = BOARD_SIZE / WORD_WIDTH;

  localparam logic [10:0] H_LIM  = 11'(BOARD_SIZE);
  localparam logic [9:0]  V_LIM  = 10'(BOARD_SIZE);
  localparam logic [10:0] H_LAST = 11'(BOARD_SIZE - 1);
  localparam logic [9:0]  V_LAST = 10'(BOARD_SIZE - 1);

  // Everything about a pixel that must travel alongside its cell value.
  typedef struct packed {
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        in_board;
  } side_t;

  side_t                   side_in;
  side_t                   side_q [LATENCY];

  logic                    in_board_w;
  logic                    boundary_w;
  logic [ADDR_WIDTH-1:0]   rd_addr_w;

  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [READ_LATENCY-1:0] rd_vld_q;

  logic                    load_w;
  logic                    align_inb_w;
  logic [WORD_WIDTH-1:0]   word_q, word_d;
  logic                    word_valid_q, word_valid_d;
  logic                    cell_q, cell_d;

  logic                    scan_active_q, scan_active_d;
  logic                    frame_done_q, frame_done_d;

  // Next-state logic for read issue, word shifting and frame bookkeeping.
  always_comb begin
    in_board_w = (hcount_in < H_LIM) && (vcount_in < V_LIM);
    boundary_w = (hcount_in[WSH-1:0] == '0);
    rd_addr_w  = ADDR_WIDTH'(vcount_in) * ADDR_WIDTH'(WPR) + ADDR_WIDTH'(hcount_in >> WSH);

    side_in.hcount   = hcount_in;
    side_in.vcount   = vcount_in;
    side_in.hsync    = hsync_in;
    side_in.vsync    = vsync_in;
    side_in.blank    = blank_in;
    side_in.in_board = in_board_w;

    // One fetch per word, issued as the raster crosses its first cell.
    rd_en_d   = in_board_w && boundary_w;
    rd_addr_d = rd_en_d ? rd_addr_w : rd_addr_q;

    // The returning word lines up with the pixel one stage short of the output.
    load_w      = rd_vld_q[READ_LATENCY-1];
    align_inb_w = side_q[LATENCY-2].in_board;

    word_d       = load_w ? rd_data_in : (word_q >> 1);
    word_valid_d = load_w || (word_valid_q && align_inb_w);
    cell_d       = align_inb_w && word_valid_d && word_d[0];

    // Pulse one cycle after the last board pixel leaves, only if this frame's scan was seen from (0,0).
    frame_done_d = scan_active_q && side_q[LATENCY-1].in_board &&
                   (side_q[LATENCY-1].hcount == H_LAST) &&
                   (side_q[LATENCY-1].vcount == V_LAST);

    scan_active_d = scan_active_q;
    if (frame_done_d) begin
      scan_active_d = 1'b0;
    end else if (rd_en_d && (hcount_in == '0) && (vcount_in == '0)) begin
      scan_active_d = 1'b1;
    end
  end

  // Sideband delay line; reset flushes it so timing outputs read 0 until refilled.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < LATENCY; i++) begin
        side_q[i] <= '0;
      end
    end else begin
      side_q[0] <= side_in;
      for (int i = 1; i < LATENCY; i++) begin
        side_q[i] <= side_q[i-1];
      end
    end
  end

  // Read strobe/address and the in-flight read tracker; reset drops pending reads.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_vld_q  <= '0;
    end else begin
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q[0] <= rd_en_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
      end
    end
  end

  // Word register, its valid flag, the cell output and frame tracking.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      cell_q        <= 1'b0;
      scan_active_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      word_q        <= word_d;
      word_valid_q  <= word_valid_d;
      cell_q        <= cell_d;
      scan_active_q <= scan_active_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign rd_en_out       = rd_en_q;
  assign rd_addr_out     = rd_addr_q;
  assign cell_alive_out  = cell_q;
  assign hcount_out      = side_q[LATENCY-1].hcount;
  assign vcount_out      = side_q[LATENCY-1].vcount;
  assign hsync_out       = side_q[LATENCY-1].hsync;
  assign vsync_out       = side_q[LATENCY-1].vsync;
  assign blank_out       = side_q[LATENCY-1].blank;
  assign scan_active_out = scan_active_q;
  assign frame_done_out  = frame_done_q;

endmodule

// File: tb/tb_board_scanner.sv
// Bench for board_scanner: directed raster stimulus, a BRAM model and a cycle-history reference model.
// Every output is compared each cycle against the model, plus literal spot checks per scenario.
// The raster never stalls, so the bench only bounds total runtime.
module tb_board_scanner;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in;
  logic        rd_en_out;
  logic [11:0] rd_addr_out;
  logic [15:0] rd_data_in = 16'h0000;
  logic        cell_alive_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, blank_out;
  logic        scan_active_out, frame_done_out;

  always #5 clk_in = ~clk_in;

  board_scanner dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .cell_alive_out(cell_alive_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .scan_active_out(scan_active_out), .frame_done_out(frame_done_out)
  );

  // Board memory with a fixed two-cycle read latency.
  logic [15:0] mem [0:4095];
  logic [15:0] mem_s1 = 16'h0000;
  bit          force_ff = 1'b0;
  always @(posedge clk_in) begin
    mem_s1     <= mem[rd_addr_out];
    rd_data_in <= force_ff ? 16'hFFFF : mem_s1;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp_v);
    end
  endtask

  // Per-cycle record of what was presented, plus which fetched word (if any) covers that pixel.
  typedef struct {
    int h; int v;
    bit hs; bit vs; bit bl; bit rst; bit inb;
    bit ok; int s; int addr;
  } rec_t;
  rec_t rec [64];

  function automatic bit rst_win(input int a, input int b);
    for (int k = a; k <= b; k++) begin
      if (k < 0) return 1'b1;
      if (rec[k % 64].rst) return 1'b1;
    end
    return 1'b0;
  endfunction

  bit scan_m = 1'b0;
  int addr_m = 0;
  bit last_prev = 1'b0;
  int fd_seen = 0;
  int fd_cyc = -1;

  bit lg_cell [256];
  bit lg_en   [256];
  bit lg_hs   [256];
  bit lg_bl   [256];
  bit lg_scan [256];
  int lg_addr [256];
  int lg_h    [256];

  // Reference model and per-cycle comparison.
  always @(negedge clk_in) begin : cmp
    rec_t r, p, o;
    int n;
    bit clean, en, fd_exp, exp_cell, inb_out;
    n = cyc;
    if (n >= 1) begin
      r.h = int'(hcount_in); r.v = int'(vcount_in);
      r.hs = hsync_in; r.vs = vsync_in; r.bl = blank_in; r.rst = rst_in;
      r.inb = (r.h < 256) && (r.v < 256);
      p = rec[(n - 1) % 64];
      r.s = n; r.addr = 0; r.ok = 1'b0;
      if (!r.rst && r.inb && (r.h % 16 == 0)) begin
        r.ok = 1'b1; r.s = n; r.addr = r.v * 16 + r.h / 16;
      end else if (!r.rst && r.inb) begin
        r.ok = p.ok; r.s = p.s; r.addr = p.addr;
      end
      rec[n % 64] = r;

      clean = !rst_win(n - 4, n - 1);
      o = rec[(n + 60) % 64];
      inb_out = clean && o.inb;
      exp_cell = inb_out && o.ok && !rst_win(o.s, n - 1) && mem[o.addr][o.h % 16];

      en = !p.rst && p.inb && (p.h % 16 == 0);
      if (p.rst) addr_m = 0;
      else if (en) addr_m = p.v * 16 + p.h / 16;
      fd_exp = !p.rst && scan_m && last_prev;
      if (p.rst || fd_exp) scan_m = 1'b0;
      else if (en && p.h == 0 && p.v == 0) scan_m = 1'b1;
      last_prev = inb_out && (o.h == 255) && (o.v == 255);

      chk("rd_en", int'(rd_en_out), int'(en));
      chk("rd_addr", int'(rd_addr_out), addr_m);
      chk("cell_alive", int'(cell_alive_out), int'(exp_cell));
      chk("hcount_out", int'(hcount_out), clean ? o.h : 0);
      chk("vcount_out", int'(vcount_out), clean ? o.v : 0);
      chk("hsync_out", int'(hsync_out), clean ? int'(o.hs) : 0);
      chk("vsync_out", int'(vsync_out), clean ? int'(o.vs) : 0);
      chk("blank_out", int'(blank_out), clean ? int'(o.bl) : 0);
      chk("scan_active", int'(scan_active_out), int'(scan_m));
      chk("frame_done", int'(frame_done_out), int'(fd_exp));

      lg_cell[n % 256] = cell_alive_out;
      lg_en[n % 256]   = rd_en_out;
      lg_hs[n % 256]   = hsync_out;
      lg_bl[n % 256]   = blank_out;
      lg_scan[n % 256] = scan_active_out;
      lg_addr[n % 256] = int'(rd_addr_out);
      lg_h[n % 256]    = int'(hcount_out);
      if (frame_done_out) begin
        fd_seen++;
        fd_cyc = n;
      end
    end
  end

  task automatic drive(input int x, input int y, input bit r);
    hcount_in = 11'(x);
    vcount_in = 10'(y);
    blank_in  = !((x < 640) && (y < 480));
    hsync_in  = (x >= 656) && (x < 752);
    vsync_in  = (y >= 490) && (y < 492);
    rst_in    = r;
  endtask

  task automatic pix(input int x, input int y, input bit r);
    @(posedge clk_in);
    #1;
    drive(x, y, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(300, 300, 1'b0);
  endtask

  function automatic int sum_cell(input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(lg_cell[k % 256]);
    return s;
  endfunction

  function automatic int sum_en(input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += int'(lg_en[k % 256]);
    return s;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t8, tl, fd0, hs_low;
    for (int i = 0; i < 64; i++) begin
      rec[i].rst = 1'b1; rec[i].ok = 1'b0; rec[i].inb = 1'b0;
      rec[i].h = 0; rec[i].v = 0; rec[i].s = 0; rec[i].addr = 0;
      rec[i].hs = 1'b0; rec[i].vs = 1'b0; rec[i].bl = 1'b0;
    end
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h0005;
    mem[50] = 16'hA5C3;
    drive(0, 0, 1'b1);

    // Reset held three cycles under live in-board stimulus.
    pix(1, 0, 1'b1);
    pix(2, 0, 1'b1);
    @(negedge clk_in);
    chk("rst_rd_en_lit", int'(rd_en_out), 0);
    chk("rst_cell_lit", int'(cell_alive_out), 0);
    for (int x = 656; x < 666; x++) begin
      pix(x, 0, 1'b0);
      if (x == 656) t = cyc;
    end
    idle(8);
    hs_low = 0;
    for (int k = 0; k < 4; k++) hs_low += int'(lg_hs[(t + k) % 256]);
    chk("rel_hsync_low_lit", hs_low, 0);
    chk("rel_hsync_rise_lit", int'(lg_hs[(t + 4) % 256]), 1);

    // Single word at the board origin.
    for (int x = 0; x < 16; x++) begin
      pix(x, 0, 1'b0);
      if (x == 0) t = cyc;
    end
    idle(24);
    chk("sw_scan_before_lit", int'(lg_scan[t % 256]), 0);
    chk("sw_scan_rise_lit", int'(lg_scan[(t + 1) % 256]), 1);
    chk("sw_rd_en_lit", int'(lg_en[(t + 1) % 256]), 1);
    chk("sw_addr_lit", lg_addr[(t + 1) % 256], 0);
    chk("sw_rd_en_next_lit", int'(lg_en[(t + 2) % 256]), 0);
    chk("sw_cell0_lit", int'(lg_cell[(t + 4) % 256]), 1);
    chk("sw_cell1_lit", int'(lg_cell[(t + 5) % 256]), 0);
    chk("sw_cell2_lit", int'(lg_cell[(t + 6) % 256]), 1);
    chk("sw_cell_rest_lit", sum_cell(t + 7, t + 19), 0);
    chk("sw_hcount_first_lit", lg_h[(t + 4) % 256], 0);
    chk("sw_hcount_last_lit", lg_h[(t + 19) % 256], 15);

    // Word address arithmetic away from the origin.
    for (int x = 32; x < 48; x++) begin
      pix(x, 3, 1'b0);
      if (x == 32) t = cyc;
    end
    idle(24);
    chk("addr_rd_en_lit", int'(lg_en[(t + 1) % 256]), 1);
    chk("addr_value_lit", lg_addr[(t + 1) % 256], 50);
    chk("addr_no_more_reads_lit", sum_en(t + 2, t + 16), 0);
    chk("addr_cell_bit0_lit", int'(lg_cell[(t + 4) % 256]), 1);
    chk("addr_cell_bit2_lit", int'(lg_cell[(t + 6) % 256]), 0);

    // Pixels outside the board with the memory forced to all ones.
    force_ff = 1'b1;
    for (int x = 256; x < 260; x++) pix(x, 0, 1'b0);
    for (int x = 700; x < 704; x++) begin
      pix(x, 0, 1'b0);
      if (x == 700) t = cyc;
    end
    idle(8);
    force_ff = 1'b0;
    chk("out_rd_en_lit", sum_en(t - 4, t + 8), 0);
    chk("out_cell_lit", sum_cell(t - 4, t + 8), 0);
    chk("out_blank_low_lit", int'(lg_bl[(t + 3) % 256]), 0);
    chk("out_blank_high_lit", int'(lg_bl[(t + 4) % 256]), 1);
    idle(4);

    // Full frame with every cell alive.
    for (int i = 0; i < 4096; i++) mem[i] = 16'hFFFF;
    fd0 = fd_seen;
    for (int y = 0; y < 256; y++)
      for (int x = 0; x < 256; x++) pix(x, y, 1'b0);
    tl = cyc;
    idle(12);
    chk("ff_done_count_lit", fd_seen - fd0, 1);
    chk("ff_done_cycle_lit", fd_cyc, tl + 5);
    chk("ff_scan_after_lit", int'(lg_scan[(tl + 6) % 256]), 0);
    chk("ff_last_cell_lit", int'(lg_cell[(tl + 4) % 256]), 1);

    // Reset in the middle of a word on row 10, after a genuine (0,0) fetch.
    mem[161] = 16'h8001;
    fd0 = fd_seen;
    for (int x = 0; x < 16; x++) pix(x, 0, 1'b0);
    idle(4);
    for (int x = 0; x < 32; x++) begin
      pix(x, 10, (x >= 5) && (x < 8));
      if (x == 8) t8 = cyc;
    end
    idle(6);
    for (int x = 240; x < 256; x++) pix(x, 255, 1'b0);
    idle(12);
    chk("rm_cells_zero_lit", sum_cell(t8 + 4, t8 + 11), 0);
    chk("rm_cell_x16_lit", int'(lg_cell[(t8 + 12) % 256]), 1);
    chk("rm_cell_x17_lit", int'(lg_cell[(t8 + 13) % 256]), 0);
    chk("rm_cell_x31_lit", int'(lg_cell[(t8 + 27) % 256]), 1);
    chk("rm_scan_cleared_lit", int'(lg_scan[(t8 + 1) % 256]), 0);
    chk("rm_no_done_lit", fd_seen - fd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_scanner.md
Name: board_scanner

Overview:
- Sits directly upstream of the renderer.
- Converts raw VGA timing (hcount/vcount/sync/blank) into a per-pixel cell_alive stream by reading the packed board memory one word at a time.
- Delays all sideband timing signals so they stay cycle-aligned with cell_alive_out.
- Tells the board updater when the visible board has been fully scanned, so memory writes cannot tear a frame.

Parameters:
- BOARD_SIZE, 256, board edge in cells; one cell = one pixel; must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 16, cells per board-memory word; power of two.
- READ_LATENCY, 2, cycles from rd_addr_out valid to rd_data_in valid (fixed BRAM latency).
- ADDR_WIDTH, 12, equals log2(BOARD_SIZE*BOARD_SIZE/WORD_WIDTH).

Ports:
- clk_in  input  1  pixel clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- hcount_in  input  11  pixel x from the VGA timing generator.
- vcount_in  input  10  pixel y from the VGA timing generator.
- hsync_in, vsync_in, blank_in  input  1 each  raw VGA timing.
- rd_en_out  output  1  board-memory read strobe.
- rd_addr_out  output  ADDR_WIDTH  board-memory word address.
- rd_data_in  input  WORD_WIDTH  board-memory read data; bit k = cell x offset k.
- cell_alive_out  output  1  state of the cell under the delayed pixel.
- hcount_out, vcount_out  output  11/10  hcount/vcount delayed by LATENCY.
- hsync_out, vsync_out, blank_out  output  1 each  delayed timing.
- scan_active_out  output  1  high while the board region of the current frame is being read.
- frame_done_out  output  1  one-cycle pulse at the end of the board scan.

Behaviour:
- Clock and reset: single clock clk_in; reset rst_in is synchronous and active-high.
- LATENCY = READ_LATENCY + 2 (default 4), applied identically to every delayed output.
- in_board = (hcount_in < BOARD_SIZE) && (vcount_in < BOARD_SIZE).
- Read issue:
  - When in_board and hcount_in[log2(WORD_WIDTH)-1:0] == 0, register rd_en_out=1 next cycle.
  - Address: rd_addr_out = vcount_in*(BOARD_SIZE/WORD_WIDTH) + (hcount_in >> log2(WORD_WIDTH)).
  - Otherwise rd_en_out=0 and rd_addr_out holds its value.
- Read tracking: a READ_LATENCY-deep valid shift register tracks in-flight reads.
- Word capture, on the cycle the tracked read returns:
  - Load rd_data_in into the word register and set word_valid.
  - Output bit 0 on the next edge.
  - On each following cycle, shift right one bit and output bit 0.
- Output gating:
  - cell_alive_out = word bit only when the delayed in_board flag is 1 and word_valid is 1; else 0.
  - word_valid clears when the delayed in_board flag falls.
- Timing example: pixel presented at cycle t has cell_alive_out and all sideband signals at t+LATENCY.
- scan_active_out:
  - Rises with the first rd_en_out of a frame (x=0, y=0).
  - Falls together with the frame_done_out pulse.
- frame_done_out:
  - Exactly one cycle, the cycle after the output for pixel (BOARD_SIZE-1, BOARD_SIZE-1) is presented.
  - Never asserted twice per frame.
- Reset:
  - All outputs, pipelines, word register, word_valid and scan_active are cleared to 0.
  - Delayed sync/blank read 0 for LATENCY cycles after release.
- Reset mid-frame:
  - In-flight reads are discarded.
  - Pixels until the next word boundary output 0.
  - Scanning resumes at that boundary.
  - No frame_done_out pulse is emitted for a frame whose (0,0) read was missed.
- Wrap-around: a new row reloads at hcount 0; no state carries across rows except delayed signals.
- Simultaneous events: rst_in takes priority over every other action.

Test Plan:
- Reset: hold rst_in 3 cycles with active stimulus -> all outputs 0, rd_en_out 0; sideband outputs 0 for 4 cycles after release.
- Single word: mem[0]=16'h0005, drive x=0..15 at y=0 from cycle t -> rd_en_out=1 with addr 0 at t+1; cell_alive_out at t+4..t+19 = 1,0,1,then 0s; hcount_out=0..15 aligned.
- Addressing: y=3, x=32 -> rd_addr_out=50 at t+1; no rd_en_out for x=33..47.
- Outside board: x=256 at y=0, rd_data_in=16'hFFFF -> rd_en_out 0, cell_alive_out 0, blank_out tracks blank_in at 4-cycle delay.
- Full frame, all cells alive -> scan_active_out high from (0,0) read; single frame_done_out pulse one cycle after pixel (255,255) output; scan_active_out then 0 until the next frame.
- Reset mid-word: rst_in at x=5, released at x=8, y=10 -> cell_alive_out 0 for x=8..15; correct data from x=16; no frame_done_out that frame.
